// File: rtl/dbus_arbiter.sv
// dbus_arbiter: two-master round-robin arbiter for the shared dmem channel.
// Grants are combinational, so a granted request reaches dmem_* in the same cycle.
// The owner keeps the bus for at most BURST consecutive contested grants.
// Read data is steered back to the master that issued the read, using a
// registered grant tag that matches the 1-cycle slave read latency.
module dbus_arbiter #(
  parameter int BURST = 4,
  parameter int CW    = $clog2(BURST + 1)
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        m0_wr,
  input  logic [31:0] m0_waddr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  input  logic        m0_rd,
  input  logic [31:0] m0_raddr,
  output logic [31:0] m0_rdata,
  output logic        m0_rvalid,
  output logic        m0_stall,
  input  logic        m1_wr,
  input  logic [31:0] m1_waddr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  input  logic        m1_rd,
  input  logic [31:0] m1_raddr,
  output logic [31:0] m1_rdata,
  output logic        m1_rvalid,
  output logic        m1_stall,
  output logic        dmem_wr,
  output logic [31:0] dmem_waddr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  output logic        dmem_rd,
  output logic [31:0] dmem_raddr,
  input  logic [31:0] dmem_rdata
);

  localparam logic [CW-1:0] LP_BURST = CW'(BURST);
  localparam logic [CW-1:0] LP_ONE   = CW'(1);

  logic          r_owner;
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_rsel;

  logic          w_req0;
  logic          w_req1;
  logic          w_gnt0;
  logic          w_gnt1;
  logic          w_owner_nxt;
  logic [CW-1:0] w_cnt_nxt;

  assign w_req0 = m0_wr | m0_rd;
  assign w_req1 = m1_wr | m1_rd;

  // Arbitration: pick the winner for this cycle and compute the next owner/burst count.
  // While rstn is low nobody is granted, so the bus stays idle and stalls follow requests.
  always_comb begin
    w_gnt0      = 1'b0;
    w_gnt1      = 1'b0;
    w_owner_nxt = r_owner;
    w_cnt_nxt   = r_cnt;
    if (rstn) begin
      if (!w_req0 && !w_req1) begin
        w_cnt_nxt = '0;
      end else if (w_req0 != w_req1) begin
        // Uncontested: the sole requester always wins; the count saturates at BURST.
        w_gnt0 = w_req0;
        w_gnt1 = w_req1;
        if (w_req1 == r_owner) begin
          w_cnt_nxt = (r_cnt == LP_BURST) ? LP_BURST : r_cnt + LP_ONE;
        end else begin
          w_owner_nxt = w_req1;
          w_cnt_nxt   = LP_ONE;
        end
      end else if (r_cnt < LP_BURST) begin
        // Contested, owner still inside its burst allowance.
        w_gnt0    = ~r_owner;
        w_gnt1    = r_owner;
        w_cnt_nxt = r_cnt + LP_ONE;
      end else begin
        // Contested, burst exhausted: hand the bus to the waiting master.
        w_gnt0      = r_owner;
        w_gnt1      = ~r_owner;
        w_owner_nxt = ~r_owner;
        w_cnt_nxt   = LP_ONE;
      end
    end
  end

  // Ownership, burst count and read-return tag registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_owner <= 1'b0;
      r_cnt   <= '0;
      r_rsel  <= 2'b00;
    end else begin
      r_owner <= w_owner_nxt;
      r_cnt   <= w_cnt_nxt;
      r_rsel  <= {w_gnt1 & m1_rd, w_gnt0 & m0_rd};
    end
  end

  // Bus mux: the granted master drives dmem_*; with no grant everything is zero.
  always_comb begin
    dmem_wr    = 1'b0;
    dmem_waddr = '0;
    dmem_wdata = '0;
    dmem_wstrb = '0;
    dmem_rd    = 1'b0;
    dmem_raddr = '0;
    if (w_gnt0) begin
      dmem_wr    = m0_wr;
      dmem_waddr = m0_waddr;
      dmem_wdata = m0_wdata;
      dmem_wstrb = m0_wstrb;
      dmem_rd    = m0_rd;
      dmem_raddr = m0_raddr;
    end else if (w_gnt1) begin
      dmem_wr    = m1_wr;
      dmem_waddr = m1_waddr;
      dmem_wdata = m1_wdata;
      dmem_wstrb = m1_wstrb;
      dmem_rd    = m1_rd;
      dmem_raddr = m1_raddr;
    end
  end

  assign m0_stall  = w_req0 & ~w_gnt0;
  assign m1_stall  = w_req1 & ~w_gnt1;
  assign m0_rvalid = r_rsel[0];
  assign m1_rvalid = r_rsel[1];
  assign m0_rdata  = r_rsel[0] ? dmem_rdata : '0;
  assign m1_rdata  = r_rsel[1] ? dmem_rdata : '0;

endmodule

// File: tb/tb_dbus_arbiter.sv
// Bench for dbus_arbiter: a table of per-cycle vectors for BURST=4, plus a
// hand-written strict-alternation sequence on a second instance with BURST=1.
module tb_dbus_arbiter;

  logic        clk = 1'b0;
  logic        rstn;
  logic        m0_wr, m0_rd, m1_wr, m1_rd;
  logic [31:0] m0_waddr, m0_wdata, m0_raddr;
  logic [31:0] m1_waddr, m1_wdata, m1_raddr;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic [31:0] dmem_rdata;

  logic [31:0] a_m0_rdata, a_m1_rdata, a_dwaddr, a_dwdata, a_draddr;
  logic        a_m0_rvalid, a_m1_rvalid, a_m0_stall, a_m1_stall, a_dwr, a_drd;
  logic [3:0]  a_dwstrb;

  logic [31:0] b_m0_rdata, b_m1_rdata, b_dwaddr, b_dwdata, b_draddr;
  logic        b_m0_rvalid, b_m1_rvalid, b_m0_stall, b_m1_stall, b_dwr, b_drd;
  logic [3:0]  b_dwstrb;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dbus_arbiter #(.BURST(4)) u_b4 (
    .clk(clk), .rstn(rstn),
    .m0_wr(m0_wr), .m0_waddr(m0_waddr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
    .m0_rd(m0_rd), .m0_raddr(m0_raddr), .m0_rdata(a_m0_rdata), .m0_rvalid(a_m0_rvalid),
    .m0_stall(a_m0_stall),
    .m1_wr(m1_wr), .m1_waddr(m1_waddr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_rd(m1_rd), .m1_raddr(m1_raddr), .m1_rdata(a_m1_rdata), .m1_rvalid(a_m1_rvalid),
    .m1_stall(a_m1_stall),
    .dmem_wr(a_dwr), .dmem_waddr(a_dwaddr), .dmem_wdata(a_dwdata), .dmem_wstrb(a_dwstrb),
    .dmem_rd(a_drd), .dmem_raddr(a_draddr), .dmem_rdata(dmem_rdata)
  );

  dbus_arbiter #(.BURST(1)) u_b1 (
    .clk(clk), .rstn(rstn),
    .m0_wr(m0_wr), .m0_waddr(m0_waddr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
    .m0_rd(m0_rd), .m0_raddr(m0_raddr), .m0_rdata(b_m0_rdata), .m0_rvalid(b_m0_rvalid),
    .m0_stall(b_m0_stall),
    .m1_wr(m1_wr), .m1_waddr(m1_waddr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_rd(m1_rd), .m1_raddr(m1_raddr), .m1_rdata(b_m1_rdata), .m1_rvalid(b_m1_rvalid),
    .m1_stall(b_m1_stall),
    .dmem_wr(b_dwr), .dmem_waddr(b_dwaddr), .dmem_wdata(b_dwdata), .dmem_wstrb(b_dwstrb),
    .dmem_rd(b_drd), .dmem_raddr(b_draddr), .dmem_rdata(dmem_rdata)
  );

  // One cycle of stimulus; g = expected grant (0 none, 1 master 0, 2 master 1).
  typedef struct {
    logic       rst;
    logic       w0, r0, w1, r1;
    logic [1:0] g;
    logic       rv0, rv1;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic rst, input logic w0, input logic r0,
                              input logic w1, input logic r1, input logic [1:0] g,
                              input logic rv0, input logic rv1);
    vec_t v;
    v.rst = rst; v.w0 = w0; v.r0 = r0; v.w1 = w1; v.r1 = r1;
    v.g = g; v.rv0 = rv0; v.rv1 = rv1;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec %0d: got %h want %h", nm, idx, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic w0, input logic r0,
                       input logic w1, input logic r1, input int idx);
    rstn       = ~rst;
    m0_wr      = w0;
    m0_rd      = r0;
    m1_wr      = w1;
    m1_rd      = r1;
    m1_raddr   = 32'h0100_0000 + 32'(4 * idx);
    dmem_rdata = 32'hA000_0000 | 32'(idx);
  endtask

  initial begin
    logic        eg0, eg1;
    logic [31:0] e_wa, e_wd, e_ra;
    logic [3:0]  e_ws;
    logic        e_wr, e_rd;

    rstn     = 1'b0;
    m0_wr = 1'b0; m0_rd = 1'b0; m1_wr = 1'b0; m1_rd = 1'b0;
    m0_waddr = 32'h0000_1000; m0_wdata = 32'h1111_1111; m0_wstrb = 4'hF;
    m0_raddr = 32'h0200_0004;
    m1_waddr = 32'h0300_0000; m1_wdata = 32'hDEAD_BEEF; m1_wstrb = 4'b0011;
    m1_raddr = 32'h0100_0000;
    dmem_rdata = 32'h0;

    // reset with m0 reading, then one granted read and an idle cycle
    tbl.push_back(mk(1, 0,1, 0,0, 0, 0,0));
    tbl.push_back(mk(0, 0,1, 0,0, 1, 0,0));
    tbl.push_back(mk(0, 0,0, 0,0, 0, 1,0));
    // contention from owner=0, cnt=0: m0 x4, m1 x4, m0 x4
    tbl.push_back(mk(0, 0,1, 0,1, 1, 0,0));
    tbl.push_back(mk(0, 0,1, 0,1, 1, 1,0));
    tbl.push_back(mk(0, 0,1, 0,1, 1, 1,0));
    tbl.push_back(mk(0, 0,1, 0,1, 1, 1,0));
    tbl.push_back(mk(0, 0,1, 0,1, 2, 1,0));
    tbl.push_back(mk(0, 0,1, 0,1, 2, 0,1));
    tbl.push_back(mk(0, 0,1, 0,1, 2, 0,1));
    tbl.push_back(mk(0, 0,1, 0,1, 2, 0,1));
    tbl.push_back(mk(0, 0,1, 0,1, 1, 0,1));
    tbl.push_back(mk(0, 0,1, 0,1, 1, 1,0));
    tbl.push_back(mk(0, 0,1, 0,1, 1, 1,0));
    tbl.push_back(mk(0, 0,1, 0,1, 1, 1,0));
    // idle clears cnt; m0 builds cnt=2 (first with wr+rd together), then drops
    tbl.push_back(mk(0, 0,0, 0,0, 0, 1,0));
    tbl.push_back(mk(0, 1,1, 0,0, 1, 0,0));
    tbl.push_back(mk(0, 0,1, 0,1, 1, 1,0));
    tbl.push_back(mk(0, 0,0, 0,1, 2, 1,0));
    tbl.push_back(mk(0, 0,1, 0,1, 2, 0,1));
    tbl.push_back(mk(0, 0,1, 0,1, 2, 0,1));
    tbl.push_back(mk(0, 0,1, 0,1, 2, 0,1));
    tbl.push_back(mk(0, 0,1, 0,1, 1, 0,1));
    // write routing: m1 takes ownership with a write, then wins vs m0 read
    tbl.push_back(mk(0, 0,0, 1,0, 2, 1,0));
    tbl.push_back(mk(0, 0,1, 1,0, 2, 0,0));
    tbl.push_back(mk(0, 0,1, 0,0, 1, 0,0));
    tbl.push_back(mk(0, 0,0, 0,0, 0, 1,0));
    // reset mid-burst with a read outstanding
    tbl.push_back(mk(0, 0,1, 0,1, 1, 0,0));
    tbl.push_back(mk(1, 0,1, 0,1, 0, 0,0));
    tbl.push_back(mk(0, 0,1, 0,1, 1, 0,0));
    tbl.push_back(mk(0, 0,1, 0,1, 1, 1,0));
    tbl.push_back(mk(0, 0,0, 0,0, 0, 1,0));
    // solo master 1 for 8 cycles
    tbl.push_back(mk(0, 0,0, 0,1, 2, 0,0));
    for (int k = 0; k < 7; k++) tbl.push_back(mk(0, 0,0, 0,1, 2, 0,1));
    tbl.push_back(mk(0, 0,0, 0,0, 0, 0,1));

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      drive(tbl[i].rst, tbl[i].w0, tbl[i].r0, tbl[i].w1, tbl[i].r1, i);
      #1;
      eg0 = (tbl[i].g == 2'd1);
      eg1 = (tbl[i].g == 2'd2);
      e_wr = 1'b0; e_rd = 1'b0; e_wa = '0; e_wd = '0; e_ws = '0; e_ra = '0;
      if (eg0) begin
        e_wr = m0_wr; e_rd = m0_rd; e_wa = m0_waddr; e_wd = m0_wdata;
        e_ws = m0_wstrb; e_ra = m0_raddr;
      end else if (eg1) begin
        e_wr = m1_wr; e_rd = m1_rd; e_wa = m1_waddr; e_wd = m1_wdata;
        e_ws = m1_wstrb; e_ra = m1_raddr;
      end
      chk("m0_stall",   i, 32'(a_m0_stall),  32'((tbl[i].w0 | tbl[i].r0) & ~eg0));
      chk("m1_stall",   i, 32'(a_m1_stall),  32'((tbl[i].w1 | tbl[i].r1) & ~eg1));
      chk("dmem_wr",    i, 32'(a_dwr),       32'(e_wr));
      chk("dmem_rd",    i, 32'(a_drd),       32'(e_rd));
      chk("dmem_waddr", i, a_dwaddr,         e_wa);
      chk("dmem_wdata", i, a_dwdata,         e_wd);
      chk("dmem_wstrb", i, 32'(a_dwstrb),    32'(e_ws));
      chk("dmem_raddr", i, a_draddr,         e_ra);
      chk("m0_rvalid",  i, 32'(a_m0_rvalid), 32'(tbl[i].rv0));
      chk("m1_rvalid",  i, 32'(a_m1_rvalid), 32'(tbl[i].rv1));
      chk("m0_rdata",   i, a_m0_rdata,       tbl[i].rv0 ? dmem_rdata : 32'h0);
      chk("m1_rdata",   i, a_m1_rdata,       tbl[i].rv1 ? dmem_rdata : 32'h0);
    end

    // BURST=1: from reset, both reading continuously -> m0, m1, m0, m1
    @(negedge clk);
    drive(1, 0,1, 0,1, 100);
    #1;
    chk("b1_rst_m0_stall", 100, 32'(b_m0_stall), 32'd1);
    chk("b1_rst_dmem_rd",  100, 32'(b_drd),      32'd0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      drive(0, 0,1, 0,1, 101 + k);
      #1;
      chk("b1_m0_stall",  101 + k, 32'(b_m0_stall),  32'(k % 2));
      chk("b1_m1_stall",  101 + k, 32'(b_m1_stall),  32'((k + 1) % 2));
      chk("b1_raddr",     101 + k, b_draddr, (k % 2 == 0) ? m0_raddr : m1_raddr);
      chk("b1_m0_rvalid", 101 + k, 32'(b_m0_rvalid), 32'((k > 0) && (k % 2 == 1)));
      chk("b1_m1_rvalid", 101 + k, 32'(b_m1_rvalid), 32'((k > 0) && (k % 2 == 0)));
      chk("b1_m1_rdata",  101 + k, b_m1_rdata,
          ((k > 0) && (k % 2 == 0)) ? dmem_rdata : 32'h0);
    end

    @(negedge clk);
    drive(0, 0,0, 0,0, 200);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dbus_arbiter.md
# dbus_arbiter

Two-master arbiter for the CPU data bus. It shares the single dmem read/write channel, which feeds the rbus/wbus decoders for IRAM, DRAM, UART and SEGLED, between master 0 (the RISC-V core) and master 1 (a secondary master such as a UART loader or DMA engine). Arbitration is round-robin with a bounded burst, and losers receive a combinational stall. Read data is routed back using a registered grant tag, matching the 1-cycle read latency of the slaves.

## Interface
- BURST, 4, max consecutive granted cycles for the owner while the other master waits (≥1; 1 = strict alternation)
- CW, $clog2(BURST+1), burst counter width (derived, do not override)

Ports:
- clk  in  1  system clock, all state on rising edge
- rstn  in  1  reset, asynchronous, active-low
- m0_wr, m1_wr  in  1  master write request
- m0_waddr, m1_waddr  in  32  write byte address
- m0_wdata, m1_wdata  in  32  write data
- m0_wstrb, m1_wstrb  in  4  write byte strobes
- m0_rd, m1_rd  in  1  master read request
- m0_raddr, m1_raddr  in  32  read byte address
- m0_rdata, m1_rdata  out  32  read data, valid the cycle after a granted read
- m0_rvalid, m1_rvalid  out  1  read data valid (registered)
- m0_stall, m1_stall  out  1  request not granted this cycle; master must hold request
- dmem_wr  out  1  to bus decoders
- dmem_waddr  out  32
- dmem_wdata  out  32
- dmem_wstrb  out  4
- dmem_rd  out  1
- dmem_raddr  out  32
- dmem_rdata  in  32  muxed slave read data (1-cycle latency)

## Operation
- reqN = mN_wr | mN_rd. A grant covers both channels of one master for one cycle. Simultaneous wr+rd from one master pass through together.
- State: owner (1 bit, reset 0) and cnt (CW bits, reset 0).
- Grant (combinational, per cycle):
  - No requests: no grant; owner unchanged; cnt <= 0.
  - Only master k requests: grant k. If k == owner, cnt <= min(cnt+1, BURST). Else owner <= k, cnt <= 1.
  - Both request and cnt < BURST: grant owner; cnt <= cnt+1.
  - Both request and cnt == BURST: grant the other master; owner <= other; cnt <= 1.
- Bus mux: dmem_* = granted master's signals. With no grant, dmem_wr = dmem_rd = 0 and all address/data/strb outputs = 0.
- mN_stall = reqN & ~grantN.
- Read return: rsel_q[N] <= grantN & mN_rd (reset 0). mN_rvalid = rsel_q[N]. mN_rdata = rsel_q[N] ? dmem_rdata : 0.
- Requests are not latched internally. A stalled master presents the identical request until granted. Changing an un-granted request is legal and simply replaces it.

## Timing
- Zero-cycle arbitration: a granted request reaches dmem_* in the same cycle. Read data arrives exactly 1 cycle later.
- Uncontested master: never stalled; back-to-back transactions every cycle.
- Contested: the owner gets at most BURST consecutive grants, after which the other is guaranteed a grant. Worst-case wait = BURST cycles.
- First contested cycle after reset: master 0 wins (owner=0, cnt=0).
- Owner requests drop for one idle cycle (no requests at all): cnt clears and the next contest restarts the burst count for the current owner.
- Owner drops its request while the other requests: the other is granted immediately and ownership transfers (cnt=1).
- rstn low (async, any time including mid-burst or with a read outstanding):
  - owner=0, cnt=0, rsel_q=0; rvalid outputs 0.
  - Bus outputs forced inactive (dmem_wr=dmem_rd=0, data/addr 0); mN_stall = reqN.
  - In-flight read data is discarded.
- Stall is combinational from requests and state; no register in the request-to-stall path.

## Test plan
- Reset: rstn=0 with m0_rd=1 -> dmem_rd=0, m0_stall=1, m0_rvalid=0. Release rstn -> next cycle dmem_rd=1, dmem_raddr=m0_raddr.
- Solo master 1: m1_rd every cycle, raddr 0x0100_0000+4i, for 8 cycles -> m1_stall=0 throughout. m1_rvalid=1 from cycle 1 with m1_rdata = dmem_rdata. m0_rvalid=0.
- Contention, BURST=4: both hold requests for 12 cycles from reset -> grant sequence m0×4, m1×4, m0×4. Stall pulses are the complement. No cycle has both or neither granted.
- BURST=1: both requesting continuously -> strict alternation m0,m1,m0,m1. Each master's rvalid tracks only its own granted reads.
- Handoff: m0 owns with cnt=2. m0 drops the request while m1 requests -> m1 granted the same cycle. Next cycle m0 re-requests -> m1 keeps the grant until it reaches cnt=4.
- Write routing: m1 writes 0xDEADBEEF, wstrb=4'b0011 to 0x0300_0000 while m0 reads 0x0200_0004, owner=1, cnt<BURST -> dmem_wr=1 with m1's fields, dmem_rd=0, m0_stall=1. Next cycle m0 is granted if m1 is idle.
